// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock and is the inverse of the four-bit array multiplier: an 8-bit
//   product-width dividend is split by a 4-bit factor into quotient and
//   remainder. It uses a start/done handshake.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     start        request, sampled only while idle
//     dividend     numerator, latched on the accepting edge
//     divisor      denominator, latched on the accepting edge
//     busy         high during every division step cycle
//     done         one-cycle pulse; results are valid from this cycle
//     quotient     unsigned quotient (all ones on divide by zero)
//     remainder    unsigned remainder (zero on divide by zero)
//     div_by_zero  set together with done when the divisor was zero
// -----------------------------------------------------------------------------
module sequential_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;

  // The dividend shift register doubles as the quotient accumulator: each
  // step shifts its MSB into the partial remainder and the new quotient bit
  // into its LSB, so after DIVIDEND_W steps it holds the full quotient.
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W:0]    prem;
  logic [DIVISOR_W-1:0]  dvs;

  logic [DIVISOR_W+1:0]  step_res;
  logic [DIVISOR_W:0]    nxt_prem;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] nxt_q;

  // One restoring step. It returns {new partial remainder, quotient bit}.
  // The partial remainder stays below 2*divisor, so DIVISOR_W+1 bits never
  // overflow.
  function automatic logic [DIVISOR_W+1:0] restore_step(
    input logic [DIVISOR_W:0]   p,
    input logic                 msb,
    input logic [DIVISOR_W-1:0] d
  );
    logic [DIVISOR_W:0] sh;
    sh = {p[DIVISOR_W-1:0], msb};
    if (sh >= {1'b0, d}) begin
      return {sh - {1'b0, d}, 1'b1};
    end
    return {sh, 1'b0};
  endfunction

  always_comb begin
    step_res = restore_step(prem, dvd_sr[DIVIDEND_W-1], dvs);
    nxt_prem = step_res[DIVISOR_W+1:1];
    qbit     = step_res[0];
    nxt_q    = {dvd_sr[DIVIDEND_W-2:0], qbit};
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // Datapath: the operands are captured on the accepting edge and then
  // iterated. These registers need no reset because the FSM never uses them
  // outside BUSY.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      dvd_sr <= dividend;
      dvs    <= divisor;
      prem   <= '0;
    end else if (state == S_BUSY) begin
      dvd_sr <= nxt_q;
      prem   <= nxt_prem;
    end
  end

  // Control and result registers. The results change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_BUSY;
              cnt   <= CNT_W'(DIVIDEND_W);
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= S_DONE;
            quotient    <= nxt_q;
            remainder   <= nxt_prem[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
